// File: rtl/addr_ctrl_arb_mux.sv
// Registered N:1 address/control mux with a round-robin arbiter and owner hold.
// Optional forced-release timer is enabled by defining ARB_TIMEOUT_EN.
module addr_ctrl_arb_mux #(
  parameter int WIDTH    = 14,
  parameter int NUM_IN   = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       req,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  output logic [NUM_IN-1:0]       grant,
  output logic [WIDTH-1:0]        mux_out,
  output logic                    out_valid,
  output logic                    timeout
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  if (NUM_IN < 1 || NUM_IN > 16 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("addr_ctrl_arb_mux: NUM_IN must be 1..16 and MAX_HOLD >= 1");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_IN-1:0]  grant_q, grant_d;
  logic [WIDTH-1:0]   mux_q, mux_d;
  logic               vld_q, vld_d;

  logic [WIDTH-1:0]   bus_arr [NUM_IN];
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  int                 sum;
  logic               own_req;
  logic               others_req;
  logic               force_rel;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_bus
    assign bus_arr[g] = in_bus[g*WIDTH +: WIDTH];
  end

  function automatic logic [NUM_IN-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_IN-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NUM_IN-1)) return '0;
    return idx + PTR_W'(1);
  endfunction

  // Scan from the highest rotation offset down so the lowest offset from ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    sum       = 0;
    for (int k = NUM_IN-1; k >= 0; k--) begin
      sum = int'(ptr_q) + k;
      if (sum >= NUM_IN) sum = sum - NUM_IN;
      cand = PTR_W'(sum);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign own_req    = req[owner_q];
  assign others_req = |(req & ~grant_q);

`ifdef ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD) + 1;

  logic [HC_W-1:0] hold_q, hold_d;
  logic            timeout_q, timeout_d;

  assign force_rel = others_req && (hold_q == HC_W'(MAX_HOLD-1));
  assign timeout   = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    mux_d   = mux_q;
    vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
        vld_d   = 1'b0;
        if (win_found) begin
          state_d = OWN;
          owner_d = win_idx;
          grant_d = onehot(win_idx);
          mux_d   = bus_arr[win_idx];
          vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      OWN: begin
        if (!own_req || force_rel) begin
          state_d = IDLE;
          grant_d = '0;
          vld_d   = 1'b0;
          ptr_d   = next_ptr(owner_q);
`ifdef ARB_TIMEOUT_EN
          // A voluntary drop on the forced-release edge is not a timeout.
          timeout_d = own_req;
`endif
        end else begin
          mux_d = bus_arr[owner_q];
`ifdef ARB_TIMEOUT_EN
          if (hold_q != HC_W'(MAX_HOLD-1)) hold_d = hold_q + HC_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      mux_q   <= '0;
      vld_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      mux_q   <= mux_d;
      vld_q   <= vld_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign mux_out   = mux_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_addr_ctrl_arb_mux.sv
// Directed bench for addr_ctrl_arb_mux with NUM_IN=4, WIDTH=14, MAX_HOLD=8.
module tb_addr_ctrl_arb_mux;

  localparam int W  = 14;
  localparam int N  = 4;
  localparam int MH = 8;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   in_bus;
  logic [N-1:0]     grant;
  logic [W-1:0]     mux_out;
  logic             out_valid;
  logic             timeout;

  int vecs;
  int errs;

  addr_ctrl_arb_mux #(.WIDTH(W), .NUM_IN(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_bus    (in_bus),
    .grant     (grant),
    .mux_out   (mux_out),
    .out_valid (out_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input int i, input logic [W-1:0] v);
    in_bus[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    set_bus(0, 14'h0111);
    set_bus(1, 14'h0222);
    set_bus(2, 14'h0333);
    set_bus(3, 14'h0444);
    for (int c = 0; c < 2; c++) begin
      tick();
      vecs++;
      if (grant !== 4'b0000 || mux_out !== 14'h0000 || out_valid !== 1'b0 || timeout !== 1'b0) begin
        errs++;
        $display("FAIL reset_cyc%0d: grant=%b mux=%h vld=%b to=%b, want 0000/0000/0/0",
                 c, grant, mux_out, out_valid, timeout);
      end
    end
    rst_n = 1'b1;
    tick();
    vecs++;
    if (grant !== 4'b0001 || mux_out !== 14'h0111 || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL reset_first_grant: grant=%b mux=%h vld=%b, want 0001/0111/1", grant, mux_out, out_valid);
    end
    req = 4'b0000;
    tick();
    vecs++;
    if (grant !== 4'b0000 || out_valid !== 1'b0 || mux_out !== 14'h0111) begin
      errs++;
      $display("FAIL reset_release: grant=%b mux=%h vld=%b, want 0000/0111/0", grant, mux_out, out_valid);
    end
  endtask

  task automatic test_basic();
    req = 4'b0100;
    set_bus(2, 14'h01A5);
    tick();
    vecs++;
    if (grant !== 4'b0100 || mux_out !== 14'h01A5 || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL basic_grant: grant=%b mux=%h vld=%b, want 0100/01a5/1", grant, mux_out, out_valid);
    end
    set_bus(2, 14'h00F0);
    tick();
    vecs++;
    if (mux_out !== 14'h00F0 || grant !== 4'b0100) begin
      errs++;
      $display("FAIL basic_follow: grant=%b mux=%h, want 0100/00f0", grant, mux_out);
    end
    req = 4'b0101;
    set_bus(0, 14'h3FFF);
    tick();
    vecs++;
    if (grant !== 4'b0100 || mux_out !== 14'h00F0) begin
      errs++;
      $display("FAIL basic_ignore_other: grant=%b mux=%h, want 0100/00f0", grant, mux_out);
    end
    req = 4'b0000;
    set_bus(2, 14'h1234);
    tick();
    vecs++;
    if (grant !== 4'b0000 || out_valid !== 1'b0 || mux_out !== 14'h00F0) begin
      errs++;
      $display("FAIL basic_release_hold: grant=%b mux=%h vld=%b, want 0000/00f0/0", grant, mux_out, out_valid);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] bv;
    logic [N-1:0] eg;
    do_reset();
    for (int i = 0; i < N; i++) set_bus(i, W'(14'h0A00 + i));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      eg = 4'b0001 << order[g];
      bv = W'(14'h0A00 + order[g]);
      for (int c = 0; c < 3; c++) begin
        tick();
        vecs++;
        if (grant !== eg || mux_out !== bv || out_valid !== 1'b1) begin
          errs++;
          $display("FAIL rr_grant%0d_cyc%0d: grant=%b mux=%h vld=%b, want %b/%h/1",
                   g, c, grant, mux_out, out_valid, eg, bv);
        end
      end
      req[order[g]] = 1'b0;
      tick();
      vecs++;
      if (grant !== 4'b0000 || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL rr_idle%0d: grant=%b vld=%b, want 0000/0", g, grant, out_valid);
      end
      req[order[g]] = 1'b1;
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    set_bus(1, 14'h0B01);
    req = 4'b1000;
    tick();
    vecs++;
    if (grant !== 4'b1000) begin
      errs++;
      $display("FAIL wrap_own3: grant=%b, want 1000", grant);
    end
    req = 4'b0000;
    tick();
    req = 4'b1010;
    tick();
    vecs++;
    if (grant !== 4'b0010 || mux_out !== 14'h0B01) begin
      errs++;
      $display("FAIL wrap_next: grant=%b mux=%h, want 0010/0b01", grant, mux_out);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_own();
    set_bus(0, 14'h0C00);
    set_bus(2, 14'h2BAD);
    req = 4'b0100;
    tick();
    vecs++;
    if (grant !== 4'b0100) begin
      errs++;
      $display("FAIL midrst_own: grant=%b, want 0100", grant);
    end
    rst_n = 1'b0;
    tick();
    vecs++;
    if (grant !== 4'b0000 || out_valid !== 1'b0 || mux_out !== 14'h0000) begin
      errs++;
      $display("FAIL midrst_clear: grant=%b mux=%h vld=%b, want 0000/0000/0", grant, mux_out, out_valid);
    end
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    vecs++;
    if (grant !== 4'b0001 || mux_out !== 14'h0C00) begin
      errs++;
      $display("FAIL midrst_restart: grant=%b mux=%h, want 0001/0c00", grant, mux_out);
    end
    req = 4'b0000;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_bus(0, 14'h0D00);
    set_bus(1, 14'h0D01);
    req = 4'b0001;
    tick();
    req = 4'b0011;
    for (int c = 1; c < MH; c++) begin
      tick();
      vecs++;
      if (grant !== 4'b0001 || timeout !== 1'b0) begin
        errs++;
        $display("FAIL to_hold_cyc%0d: grant=%b to=%b, want 0001/0", c, grant, timeout);
      end
    end
    tick();
    vecs++;
    if (grant !== 4'b0000 || timeout !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL to_forced: grant=%b to=%b vld=%b, want 0000/1/0", grant, timeout, out_valid);
    end
    tick();
    vecs++;
    if (grant !== 4'b0010 || timeout !== 1'b0 || mux_out !== 14'h0D01) begin
      errs++;
      $display("FAIL to_next_owner: grant=%b to=%b mux=%h, want 0010/0/0d01", grant, timeout, mux_out);
    end
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      vecs++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin
        errs++;
        $display("FAIL to_sat_cyc%0d: grant=%b to=%b, want 0010/0", c, grant, timeout);
      end
    end
    req = 4'b0011;
    tick();
    vecs++;
    if (grant !== 4'b0000 || timeout !== 1'b1) begin
      errs++;
      $display("FAIL to_sat_release: grant=%b to=%b, want 0000/1", grant, timeout);
    end
    tick();
    vecs++;
    if (grant !== 4'b0001) begin
      errs++;
      $display("FAIL to_regrant0: grant=%b, want 0001", grant);
    end
    for (int c = 1; c < MH; c++) tick();
    req = 4'b0010;
    tick();
    vecs++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      errs++;
      $display("FAIL to_voluntary: grant=%b to=%b, want 0000/0", grant, timeout);
    end
    req = 4'b0000;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    req = 4'b0011;
    tick();
    for (int c = 0; c < 105; c++) begin
      tick();
      vecs++;
      if (grant !== 4'b0001 || timeout !== 1'b0) begin
        errs++;
        $display("FAIL nto_hold_cyc%0d: grant=%b to=%b, want 0001/0", c, grant, timeout);
      end
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    vecs   = 0;
    errs   = 0;
    rst_n  = 1'b0;
    req    = '0;
    in_bus = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_reset_mid_own();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
